// File: rtl/core_pkg.sv
// Core-wide constants and types shared by fetch, decode and execute.
// Holds the thread count, thread-id width and the canonical NOP encoding.
package core_pkg;
    localparam int CORE_THREADS  = 4;
    localparam int BITS_THREADS  = $clog2(CORE_THREADS);
    localparam int CORE_AW       = 32;
    localparam int CORE_DW       = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [BITS_THREADS-1:0] tid_t;
endpackage

// File: rtl/fetch_mt_if.sv
// Fetch-stage bus: synchronous instruction-memory port plus the F-stage outputs
// handed to decode. master = fetch side, slave = memory/decode side.
interface fetch_mt_if
    import core_pkg::*;
#(
    parameter int AW = CORE_AW,
    parameter int DW = CORE_DW,
    parameter int TW = BITS_THREADS
);
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          valid_f;
    logic [AW-1:0] pc_f;
    logic [AW-1:0] pc_plus4_f;
    logic [DW-1:0] instr_f;
    logic [TW-1:0] tid_f;

    modport master (
        output imem_en, imem_addr, valid_f, pc_f, pc_plus4_f, instr_f, tid_f,
        input  imem_rdata
    );

    modport slave (
        input  imem_en, imem_addr, valid_f, pc_f, pc_plus4_f, instr_f, tid_f,
        output imem_rdata
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester strictly after ptr, wrapping
// around so ptr itself has the lowest priority. N must be a power of two.
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);
    logic [W-1:0] cand;
    logic         hit;

    // Scan from ptr+1 up to ptr (modulo N) and latch onto the first request.
    always_comb begin
        gnt  = '0;
        idx  = ptr;
        any  = 1'b0;
        cand = '0;
        hit  = 1'b0;
        for (int i = 1; i <= N; i++) begin
            cand      = ptr + W'(i);
            hit       = req[cand] & ~any;
            gnt[cand] = gnt[cand] | hit;
            idx       = hit ? cand : idx;
            any       = any | hit;
        end
    end
endmodule

// File: rtl/fetch_mt.sv
// Barrel instruction fetch: one PC per hardware thread, round-robin issue into a
// synchronous imem, per-thread redirects from execute, stall with data hold.
module fetch_mt
    import core_pkg::*;
#(
    parameter  int                     ADDRESS_WIDTH    = 32,
    parameter  int                     DATA_WIDTH       = 32,
    parameter  int                     NUM_THREADS      = 4,
    parameter  logic [ADDRESS_WIDTH-1:0] RESET_PC       = 32'h0000_0000,
    parameter  logic [ADDRESS_WIDTH-1:0] THREAD_PC_STRIDE = 32'h0000_1000,
    localparam int                     TW               = $clog2(NUM_THREADS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall_f,
    input  logic [NUM_THREADS-1:0]   thread_en,
    input  logic                     redirect_e,
    input  logic [TW-1:0]            tid_e,
    input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
    fetch_mt_if.master               bus
);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(3'd4);

    logic [ADDRESS_WIDTH-1:0] pc_r [NUM_THREADS];
    logic [TW-1:0]            ptr_r;
    logic [NUM_THREADS-1:0]   redir_mask_s;
    logic [NUM_THREADS-1:0]   req_s;
    logic [NUM_THREADS-1:0]   gnt_s;
    logic [TW-1:0]            sel_s;
    logic                     any_s;
    logic                     issue_s;

    logic                     valid_r;
    logic                     use_hold_r;
    logic [ADDRESS_WIDTH-1:0] pc_f_r;
    logic [TW-1:0]            tid_f_r;
    logic [DATA_WIDTH-1:0]    hold_r;

    // A thread being redirected this cycle must not issue its stale PC.
    assign redir_mask_s = {{(NUM_THREADS-1){1'b0}}, redirect_e} << tid_e;
    assign req_s        = thread_en & ~redir_mask_s;

    rr_arbiter #(.N(NUM_THREADS)) u_arb (
        .req (req_s),
        .ptr (ptr_r),
        .gnt (gnt_s),
        .idx (sel_s),
        .any (any_s)
    );

    assign issue_s       = rst_n & ~stall_f & any_s;
    assign bus.imem_en   = issue_s;
    assign bus.imem_addr = issue_s ? pc_r[sel_s] : '0;

    // Per-thread PC array: redirect wins over the post-issue increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_r[t] <= RESET_PC + ADDRESS_WIDTH'(t) * THREAD_PC_STRIDE;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                if (redirect_e && (tid_e == TW'(t))) begin
                    pc_r[t] <= pc_target_e;
                end else if (issue_s && gnt_s[t]) begin
                    pc_r[t] <= pc_r[t] + PC_STEP;
                end
            end
        end
    end

    // Round-robin pointer remembers the last thread that actually issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= TW'(NUM_THREADS - 1);
        end else if (issue_s) begin
            ptr_r <= sel_s;
        end
    end

    // F-stage registers; the hold register keeps the first-stall-cycle rdata
    // because the memory output is not guaranteed stable while imem_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= 1'b0;
            use_hold_r <= 1'b0;
            pc_f_r     <= '0;
            tid_f_r    <= '0;
            hold_r     <= '0;
        end else if (!stall_f) begin
            valid_r    <= issue_s;
            use_hold_r <= 1'b0;
            if (issue_s) begin
                pc_f_r  <= pc_r[sel_s];
                tid_f_r <= sel_s;
            end
        end else begin
            use_hold_r <= 1'b1;
            if (!use_hold_r) begin
                hold_r <= bus.imem_rdata;
            end
            if (redirect_e && (tid_e == tid_f_r)) begin
                valid_r <= 1'b0;
            end
        end
    end

    assign bus.valid_f    = valid_r;
    assign bus.pc_f       = pc_f_r;
    assign bus.pc_plus4_f = pc_f_r + PC_STEP;
    assign bus.tid_f      = tid_f_r;
    assign bus.instr_f    = !valid_r    ? DATA_WIDTH'(NOP_INSTR) :
                            use_hold_r  ? hold_r : bus.imem_rdata;
endmodule

// File: tb/tb_fetch_mt.sv
// Bench for fetch_mt: table of per-cycle stimulus with hand-derived issue
// addresses, plus a scoreboard queue of expected F-stage outputs.
module tb_fetch_mt;
    import core_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall_f;
    logic [3:0]  thread_en;
    logic        redirect_e;
    logic [1:0]  tid_e;
    logic [31:0] pc_target_e;

    fetch_mt_if #(.AW(32), .DW(32), .TW(2)) bus ();

    fetch_mt dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_f     (stall_f),
        .thread_en   (thread_en),
        .redirect_e  (redirect_e),
        .tid_e       (tid_e),
        .pc_target_e (pc_target_e),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Memory returns garbage on idle cycles so a missing hold register shows up.
    always @(posedge clk) begin
        bus.imem_rdata <= bus.imem_en ? memfn(bus.imem_addr) : $urandom;
    end

    typedef struct {
        logic        stall;
        logic [3:0]  en;
        logic        redir;
        logic [1:0]  tide;
        logic [31:0] tgt;
        logic        exp_en;
        logic [31:0] exp_addr;
        logic [1:0]  exp_tid;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [1:0]  tid;
    } fexp_t;

    vec_t  tbl [$];
    fexp_t sb  [$];
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic s, input logic [3:0] e, input logic r,
                               input logic [1:0] te, input logic [31:0] tg,
                               input logic xe, input logic [31:0] xa, input logic [1:0] xt);
        vec_t x;
        x.stall = s; x.en = e; x.redir = r; x.tide = te; x.tgt = tg;
        x.exp_en = xe; x.exp_addr = xa; x.exp_tid = xt;
        return x;
    endfunction

    task automatic chk_f(input string tag, input fexp_t x);
        chk({tag, " valid_f"},    {31'd0, bus.valid_f}, {31'd0, x.valid});
        chk({tag, " pc_f"},       bus.pc_f, x.pc);
        chk({tag, " pc_plus4_f"}, bus.pc_plus4_f, x.pc + 32'd4);
        chk({tag, " tid_f"},      {30'd0, bus.tid_f}, {30'd0, x.tid});
        chk({tag, " instr_f"},    bus.instr_f, x.valid ? memfn(x.pc) : NOP_INSTR);
    endtask

    fexp_t cur;
    fexp_t nxt;

    initial begin
        // all enabled, no stall: rows 0-4
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_0000, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_1000, 1));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_2000, 2));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_3000, 3));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_0004, 0));
        // threads 0,2 only: rows 5-7
        tbl.push_back(v(0, 4'b0101, 0, 0, 0, 1, 32'h0000_2004, 2));
        tbl.push_back(v(0, 4'b0101, 0, 0, 0, 1, 32'h0000_0008, 0));
        tbl.push_back(v(0, 4'b0101, 0, 0, 0, 1, 32'h0000_2008, 2));
        // all parked: row 8, then resume
        tbl.push_back(v(0, 4'h0, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_3004, 3));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_000C, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_1004, 1));
        // redirect thread 1 while it sits in F: row 12
        tbl.push_back(v(0, 4'b0010, 1, 1, 32'h80, 0, 32'h0, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_200C, 2));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_3008, 3));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_0010, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_0080, 1));
        // three-cycle stall then release: rows 17-21
        tbl.push_back(v(1, 4'hF, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(v(1, 4'hF, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(v(1, 4'hF, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_2010, 2));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_300C, 3));
        // redirect of the held thread during stall: rows 22-29
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_0014, 0));
        tbl.push_back(v(1, 4'hF, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(v(1, 4'hF, 1, 0, 32'h40, 0, 32'h0, 0));
        tbl.push_back(v(1, 4'hF, 0, 0, 0, 0, 32'h0, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_0084, 1));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_2014, 2));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_3010, 3));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_0040, 0));
        // redirect of another thread during stall keeps F valid: rows 30-32
        tbl.push_back(v(1, 4'hF, 1, 2, 32'h2100, 0, 32'h0, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_0088, 1));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_2100, 2));
        // PC wrap on thread 3: rows 33-41
        tbl.push_back(v(0, 4'hF, 1, 3, 32'hFFFF_FFFC, 1, 32'h0000_0044, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_008C, 1));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_2104, 2));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'hFFFF_FFFC, 3));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_0048, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_0090, 1));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_2108, 2));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_0000, 3));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 32'h0000_004C, 0));

        rst_n       = 1'b0;
        stall_f     = 1'b0;
        thread_en   = 4'hF;
        redirect_e  = 1'b0;
        tid_e       = 2'd0;
        pc_target_e = 32'd0;
        bus.imem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset imem_en", {31'd0, bus.imem_en}, 32'd0);
        cur.valid = 1'b0; cur.pc = 32'd0; cur.tid = 2'd0;
        sb.push_back(cur);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            stall_f     = tbl[i].stall;
            thread_en   = tbl[i].en;
            redirect_e  = tbl[i].redir;
            tid_e       = tbl[i].tide;
            pc_target_e = tbl[i].tgt;
            @(negedge clk);
            chk($sformatf("row%0d imem_en", i), {31'd0, bus.imem_en}, {31'd0, tbl[i].exp_en});
            if (tbl[i].exp_en)
                chk($sformatf("row%0d imem_addr", i), bus.imem_addr, tbl[i].exp_addr);
            if (sb.size() == 0) begin
                chk($sformatf("row%0d scoreboard empty", i), 32'd0, 32'd1);
                cur.valid = 1'b0; cur.pc = 32'd0; cur.tid = 2'd0;
            end else begin
                cur = sb.pop_front();
            end
            chk_f($sformatf("row%0d", i), cur);
            nxt = cur;
            if (tbl[i].stall) begin
                if (tbl[i].redir && cur.valid && (cur.tid == tbl[i].tide))
                    nxt.valid = 1'b0;
            end else begin
                nxt.valid = tbl[i].exp_en;
                if (tbl[i].exp_en) begin
                    nxt.pc  = tbl[i].exp_addr;
                    nxt.tid = tbl[i].exp_tid;
                end
            end
            sb.push_back(nxt);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of the stream.
        stall_f    = 1'b0;
        thread_en  = 4'hF;
        redirect_e = 1'b0;
        #1;
        chk("pre-reset valid_f", {31'd0, bus.valid_f}, 32'd1);
        rst_n = 1'b0;
        #1;
        cur.valid = 1'b0; cur.pc = 32'd0; cur.tid = 2'd0;
        chk_f("midreset", cur);
        chk("midreset imem_en", {31'd0, bus.imem_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset imem_en", {31'd0, bus.imem_en}, 32'd1);
        chk("post-reset imem_addr", bus.imem_addr, 32'h0000_0000);
        @(negedge clk);
        cur.valid = 1'b1; cur.pc = 32'd0; cur.tid = 2'd0;
        chk_f("post-reset", cur);
        chk("post-reset 2nd imem_addr", bus.imem_addr, 32'h0000_1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
